// File: rtl/axis_reg_pipe_rtl.sv
// AXI4-Stream register pipeline: N_STAGES slices, each a two-entry skid buffer (FULL)
// or a single forward register (FWD), with optional TKEEP/TLAST/TUSER and a beat counter.
module axis_reg_pipe_rtl #(
    parameter int N_STAGES    = 4,
    parameter int DATA_BITS   = 32,
    parameter int USER_BITS   = 1,
    parameter int KEEP_ENABLE = 0,
    parameter int LAST_ENABLE = 0,
    parameter int USER_ENABLE = 0,
    parameter int SKID_MODE   = 1,
    localparam int KEEP_BITS  = DATA_BITS / 8,
    localparam int OCC_BITS   = (N_STAGES == 0) ? 1 : $clog2(2 * N_STAGES + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic [KEEP_BITS-1:0] s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic [USER_BITS-1:0] s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [KEEP_BITS-1:0] m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [USER_BITS-1:0] m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OCC_BITS-1:0]  occupancy
);

    localparam int PAY_BITS = USER_BITS + 1 + KEEP_BITS + DATA_BITS;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} slice_state_e;

    logic [PAY_BITS-1:0] s_payload;
    logic [PAY_BITS-1:0] m_payload;

    // Disabled sideband is zeroed on entry so its flops become constants and drop out.
    assign s_payload = {(USER_ENABLE != 0) ? s_axis_tuser : {USER_BITS{1'b0}},
                        (LAST_ENABLE != 0) && s_axis_tlast,
                        (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_BITS{1'b0}},
                        s_axis_tdata};

    assign m_axis_tdata = m_payload[DATA_BITS-1:0];
    assign m_axis_tkeep = (KEEP_ENABLE != 0) ? m_payload[DATA_BITS +: KEEP_BITS] : {KEEP_BITS{1'b1}};
    assign m_axis_tlast = (LAST_ENABLE != 0) && m_payload[DATA_BITS + KEEP_BITS];
    assign m_axis_tuser = (USER_ENABLE != 0) ? m_payload[DATA_BITS + KEEP_BITS + 1 +: USER_BITS]
                                             : {USER_BITS{1'b0}};

    if (N_STAGES == 0) begin : g_wire
        assign m_payload     = s_payload;
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign occupancy     = '0;
    end else begin : g_pipe
        // link[i] is the handshake entering slice i; link[N_STAGES] is the m_axis side.
        logic [N_STAGES:0]               link_valid;
        logic [N_STAGES:0]               link_ready;
        logic [N_STAGES:0][PAY_BITS-1:0] link_data;
        logic [OCC_BITS-1:0]             occ_q;
        logic [OCC_BITS-1:0]             occ_d;
        logic                            s_fire;
        logic                            m_fire;

        assign m_axis_tvalid = link_valid[N_STAGES];
        assign m_payload     = link_data[N_STAGES];
        assign s_axis_tready = link_ready[0] && aresetn;

        assign s_fire = s_axis_tvalid && s_axis_tready;
        assign m_fire = m_axis_tvalid && m_axis_tready;

        always_comb begin
            occ_d = occ_q;
            if (s_fire && !m_fire) begin
                occ_d = occ_q + OCC_BITS'(1);
            end else if (m_fire && !s_fire) begin
                occ_d = occ_q - OCC_BITS'(1);
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;

        if (SKID_MODE != 0) begin : g_full
            slice_state_e        state_q [N_STAGES];
            slice_state_e        state_d [N_STAGES];
            logic [PAY_BITS-1:0] main_q  [N_STAGES];
            logic [PAY_BITS-1:0] main_d  [N_STAGES];
            logic [PAY_BITS-1:0] skid_q  [N_STAGES];
            logic [PAY_BITS-1:0] skid_d  [N_STAGES];
            logic [N_STAGES-1:0] rdy_q;
            logic [N_STAGES-1:0] rdy_d;
            logic [N_STAGES-1:0] in_fire;
            logic [N_STAGES-1:0] out_fire;

            always_comb begin
                link_valid = '0;
                link_ready = '0;
                link_data  = '0;
                in_fire    = '0;
                out_fire   = '0;
                rdy_d      = '0;
                link_valid[0]        = s_axis_tvalid;
                link_data[0]         = s_payload;
                link_ready[N_STAGES] = m_axis_tready;
                for (int i = 0; i < N_STAGES; i++) begin
                    link_valid[i+1] = (state_q[i] != EMPTY);
                    link_data[i+1]  = main_q[i];
                    link_ready[i]   = rdy_q[i];
                end
                for (int i = 0; i < N_STAGES; i++) begin
                    state_d[i]  = state_q[i];
                    main_d[i]   = main_q[i];
                    skid_d[i]   = skid_q[i];
                    in_fire[i]  = link_valid[i] && rdy_q[i];
                    out_fire[i] = link_valid[i+1] && link_ready[i+1];
                    case (state_q[i])
                        EMPTY: begin
                            if (in_fire[i]) begin
                                main_d[i]  = link_data[i];
                                state_d[i] = ONE;
                            end
                        end
                        ONE: begin
                            if (in_fire[i] && out_fire[i]) begin
                                main_d[i] = link_data[i];
                            end else if (in_fire[i]) begin
                                skid_d[i]  = link_data[i];
                                state_d[i] = TWO;
                            end else if (out_fire[i]) begin
                                state_d[i] = EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_fire[i]) begin
                                main_d[i]  = skid_q[i];
                                state_d[i] = ONE;
                            end
                        end
                        default: state_d[i] = EMPTY;
                    endcase
                    rdy_d[i] = (state_d[i] != TWO);
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    rdy_q <= '0;
                    for (int i = 0; i < N_STAGES; i++) begin
                        state_q[i] <= EMPTY;
                        main_q[i]  <= '0;
                        skid_q[i]  <= '0;
                    end
                end else begin
                    rdy_q <= rdy_d;
                    for (int i = 0; i < N_STAGES; i++) begin
                        state_q[i] <= state_d[i];
                        main_q[i]  <= main_d[i];
                        skid_q[i]  <= skid_d[i];
                    end
                end
            end
        end else begin : g_fwd
            logic [N_STAGES-1:0] vld_q;
            logic [N_STAGES-1:0] vld_d;
            logic [PAY_BITS-1:0] reg_q [N_STAGES];
            logic [PAY_BITS-1:0] reg_d [N_STAGES];

            // Ready ripples back from m_axis through every slice in one combinational pass.
            always_comb begin
                link_valid = '0;
                link_ready = '0;
                link_data  = '0;
                vld_d      = vld_q;
                link_valid[0]        = s_axis_tvalid;
                link_data[0]         = s_payload;
                link_ready[N_STAGES] = m_axis_tready;
                for (int i = 0; i < N_STAGES; i++) begin
                    link_valid[i+1] = vld_q[i];
                    link_data[i+1]  = reg_q[i];
                end
                for (int i = N_STAGES - 1; i >= 0; i--) begin
                    link_ready[i] = !vld_q[i] || link_ready[i+1];
                end
                for (int i = 0; i < N_STAGES; i++) begin
                    reg_d[i] = reg_q[i];
                    if (link_valid[i] && link_ready[i]) begin
                        vld_d[i] = 1'b1;
                        reg_d[i] = link_data[i];
                    end else if (link_ready[i+1]) begin
                        vld_d[i] = 1'b0;
                    end
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    vld_q <= '0;
                    for (int i = 0; i < N_STAGES; i++) begin
                        reg_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int i = 0; i < N_STAGES; i++) begin
                        reg_q[i] <= reg_d[i];
                    end
                end
            end
        end
    end

endmodule
